// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage and the shared memory arbiter.
// One outstanding read at a time: req/addr -> gnt, then rvalid/rdata.
interface if_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: owns the PC, assembles each instruction from four byte reads
// on the arbiter port, and presents if_pc/if_inst to IF/ID while holding stallreq_if low.
//
// state   | meaning
// S_REQ   | request byte pc+byte_cnt from the arbiter
// S_WAIT  | read granted, waiting for the returned byte
// S_HOLD  | full word assembled and presented to IF/ID
// S_DRAIN | discard a read that was in flight when a redirect arrived
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic [STALL_W-1:0] stall_sign,
   input  logic               br_flag,
   input  logic [31:0]        br_target,
   if_fetch_if.master         bus,
   output logic               stallreq_if,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_inst
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] word_buf;
   logic [31:0] buf_nxt;
   logic [1:0]  byte_cnt;
   logic [1:0]  cnt_nxt;
   logic        unused_stall;

   // Only bit0 (PC/IF hold) matters here; the rest of the vector is for other stages.
   assign unused_stall = ^stall_sign;

   // mem_req is also gated by rst so no request is seen while reset is asserted.
   assign bus.mem_req  = rst & (state == S_REQ);
   assign bus.mem_addr = pc + {30'd0, byte_cnt};
   assign stallreq_if  = (state != S_HOLD);
   assign if_pc        = (state == S_HOLD) ? pc       : 32'h0;
   assign if_inst      = (state == S_HOLD) ? word_buf : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         byte_cnt <= 2'd0;
         word_buf <= 32'h0;
      end else if (rdy) begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         byte_cnt <= cnt_nxt;
         word_buf <= buf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cnt_nxt   = byte_cnt;
      buf_nxt   = word_buf;

      unique case (state)
         S_REQ: begin
            if (bus.mem_gnt) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.mem_rvalid) begin
               buf_nxt[{byte_cnt, 3'b000} +: 8] = bus.mem_rdata;
               if (byte_cnt == 2'd3) begin
                  state_nxt = S_HOLD;
               end else begin
                  cnt_nxt   = byte_cnt + 2'd1;
                  state_nxt = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (!stall_sign[0]) begin
               pc_nxt    = pc + 32'd4;
               cnt_nxt   = 2'd0;
               state_nxt = S_REQ;
            end
         end
         S_DRAIN: begin
            if (bus.mem_rvalid) begin
               state_nxt = S_REQ;
            end
         end
      endcase

      // Redirect overrides any fetch progress; a read still owed to us must be drained.
      // In S_DRAIN a byte arriving with the redirect is the one being drained, so we
      // can go straight back to requesting instead of waiting for a byte that never comes.
      if (br_flag) begin
         pc_nxt  = br_target;
         cnt_nxt = 2'd0;
         buf_nxt = 32'h0;
         unique case (state)
            S_REQ:   state_nxt = bus.mem_gnt    ? S_DRAIN : S_REQ;
            S_WAIT:  state_nxt = bus.mem_rvalid ? S_REQ   : S_DRAIN;
            S_HOLD:  state_nxt = S_REQ;
            S_DRAIN: state_nxt = bus.mem_rvalid ? S_REQ   : S_DRAIN;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a behavioural arbiter/memory plus a word-level fetch model
// feed a scoreboard queue that a separate monitor checks against the presented instructions.
module tb_if_fetch;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b0;
   logic [5:0]  stall_sign = 6'd0;
   logic        br_flag = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic        stallreq_if;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   if_fetch_if bus ();

   if_fetch #(.RESET_PC(RESET_PC), .STALL_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .stall_sign  (stall_sign),
      .br_flag     (br_flag),
      .br_target   (br_target),
      .bus         (bus),
      .stallreq_if (stallreq_if),
      .if_pc       (if_pc),
      .if_inst     (if_inst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   presented = 0;

   // fetch model: word base, useful bytes received, redirect epoch
   logic [31:0] fb;
   int          k;
   int          epoch;
   // arbiter model
   bit          arb_out;
   int          arb_ep;
   logic [31:0] arb_addr;
   int          rv_cnt;
   // stimulus knobs
   int          rdy_pct, gnt_pct, br_pct, stall_pct, fixed_dly, dly_max;
   bit          br_next, stall_force, rdy_low, gnt_block;
   logic [31:0] br_tgt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [7:0] mb(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h05;
         32'd2:   return 8'h10;
         32'd3:   return 8'h00;
         default: begin
            h = a * 32'h9E37_79B1;
            return h[31:24] ^ a[7:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] word(input logic [31:0] pc);
      return {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
   endfunction

   function automatic logic [31:0] pick_tgt();
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | {28'd0, t[3:0]};
      return t;
   endfunction

   task automatic expect_word(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.inst = word(pc);
      exp_q.delete();
      exp_q.push_back(e);
   endtask

   task automatic reset_model();
      fb      = RESET_PC;
      k       = 0;
      epoch   = epoch + 1;
      arb_out = 1'b0;
      rv_cnt  = 0;
      br_next = 1'b0;
      expect_word(RESET_PC);
   endtask

   // One clock: check outputs against the model, drive inputs for the coming edge, advance model.
   task automatic step();
      bit          held, r, g, v, b, s;
      logic [31:0] tgt;
      @(negedge clk);
      if (!rst) begin
         chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
         chk("rst_stallreq", 32'(stallreq_if), 32'd1);
         bus.mem_gnt    = 1'b0;
         bus.mem_rvalid = 1'b0;
         br_flag        = 1'b0;
         return;
      end
      held = (k == 4);
      chk("mem_req", 32'(bus.mem_req), 32'(k < 4 && !arb_out));
      chk("stallreq_if", 32'(stallreq_if), 32'(!held));
      if (k < 4 && !arb_out) chk("mem_addr", bus.mem_addr, fb + 32'(k));

      r   = rdy_low ? 1'b0 : ($urandom_range(99) < rdy_pct);
      g   = r && bus.mem_req && !gnt_block && ($urandom_range(99) < gnt_pct);
      v   = r && arb_out && (rv_cnt == 0);
      b   = r && (br_next || ($urandom_range(99) < br_pct));
      s   = stall_force || ($urandom_range(99) < stall_pct);
      tgt = br_next ? br_tgt : pick_tgt();

      rdy            = r;
      bus.mem_gnt    = g;
      bus.mem_rvalid = v;
      bus.mem_rdata  = v ? mb(arb_addr) : 8'($urandom);
      br_flag        = r ? b : 1'($urandom);
      br_target      = tgt;
      stall_sign     = {5'($urandom), s};
      if (!r) return;

      if (v) begin
         arb_out = 1'b0;
         if (arb_ep == epoch && !b) k++;
      end else if (arb_out && rv_cnt > 0) begin
         rv_cnt--;
      end
      if (g) begin
         arb_out  = 1'b1;
         arb_ep   = epoch;
         arb_addr = bus.mem_addr;
         rv_cnt   = (fixed_dly > 0) ? fixed_dly - 1 : int'($urandom_range(dly_max - 1, 0));
      end
      if (b) begin
         br_next = 1'b0;
         epoch++;
         fb = tgt;
         k  = 0;
         expect_word(tgt);
      end else if (held && !s) begin
         fb = fb + 32'd4;
         k  = 0;
         expect_word(fb);
      end
   endtask

   function automatic bit cond(input int what);
      case (what)
         0:       return k == 4;
         1:       return arb_out && k == 1 && rv_cnt >= 1;
         2:       return arb_out && k == 3 && rv_cnt == 0;
         3:       return arb_out && k == 2;
         default: return k < 4 && !arb_out;
      endcase
   endfunction

   task automatic run_until(input int what, input int limit, input string nm);
      for (int i = 0; i < limit; i++) begin
         step();
         if (cond(what)) return;
      end
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=not_reached required=reached", nm);
   endtask

   // scoreboard monitor
   initial begin : monitor
      bit   prev_stall;
      exp_t held_e;
      prev_stall  = 1'b1;
      held_e.pc   = 32'h0;
      held_e.inst = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            prev_stall = 1'b1;
            continue;
         end
         if (!stallreq_if) begin
            if (prev_stall) begin
               presented++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_word actual_pc=%h required=none", if_pc);
               end else begin
                  held_e = exp_q.pop_front();
               end
            end
            chk("if_pc", if_pc, held_e.pc);
            chk("if_inst", if_inst, held_e.inst);
         end else begin
            chk("idle_if_pc", if_pc, 32'h0);
            chk("idle_if_inst", if_inst, 32'h0);
         end
         prev_stall = stallreq_if;
      end
   end

   initial begin : stimulus
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 8'h0;
      epoch     = 0;
      rdy_pct   = 100;
      gnt_pct   = 100;
      br_pct    = 0;
      stall_pct = 0;
      fixed_dly = 1;
      dly_max   = 1;
      stall_force = 1'b0;
      rdy_low     = 1'b0;
      gnt_block   = 1'b0;
      br_tgt      = 32'h0;
      reset_model();

      repeat (2) step();
      rst = 1'b1;

      // first word from reset, then held by stall_sign[0]
      stall_force = 1'b1;
      run_until(0, 40, "first_word");
      @(posedge clk);
      #1;
      chk("t1_inst", if_inst, 32'h0010_0513);
      chk("t1_pc", if_pc, RESET_PC);
      chk("t1_stallreq", 32'(stallreq_if), 32'd0);
      repeat (3) step();
      stall_force = 1'b0;
      run_until(4, 10, "after_consume");
      run_until(0, 40, "second_word");

      // redirect while a byte is in flight: that byte is drained
      fixed_dly = 3;
      run_until(1, 40, "wait_byte1");
      br_next = 1'b1;
      br_tgt  = 32'h0000_0100;
      run_until(0, 60, "word_at_100");

      // redirect coincident with the last byte's rvalid
      fixed_dly = 1;
      run_until(2, 40, "wait_byte3");
      br_next = 1'b1;
      br_tgt  = 32'h0000_0200;
      step();
      run_until(0, 60, "word_at_200");

      // async reset during the wait for byte 2
      fixed_dly = 2;
      run_until(3, 60, "wait_byte2");
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_mem_req", 32'(bus.mem_req), 32'd0);
      chk("t5_stallreq", 32'(stallreq_if), 32'd1);
      chk("t5_if_pc", if_pc, 32'h0);
      chk("t5_if_inst", if_inst, 32'h0);
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      br_flag        = 1'b0;
      reset_model();
      repeat (3) step();
      rst = 1'b1;
      run_until(0, 60, "word_after_reset");

      // rdy low while a request waits without grant
      gnt_block = 1'b1;
      run_until(4, 20, "pending_req");
      rdy_low = 1'b1;
      repeat (4) step();
      rdy_low   = 1'b0;
      gnt_block = 1'b0;
      run_until(0, 60, "word_after_pause");

      // randomized traffic
      rdy_pct   = 85;
      gnt_pct   = 60;
      br_pct    = 4;
      stall_pct = 40;
      fixed_dly = 0;
      dly_max   = 3;
      repeat (3000) step();

      chk("words_presented_min", 32'(presented >= 20), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
